// File: rtl/nlms_update_engine.sv
// rtl/nlms_update_engine.sv - NLMS coefficient update engine over a circular sample history
// Applies step*x[newest-k] plus optional leakage to LANES taps per cycle.
module nlms_update_engine #(
  parameter int TAPS       = 64,
  parameter int LANES      = 4,
  parameter int SAMPLE_W   = 16,
  parameter int COEFF_W    = 10,
  parameter int ACC_W      = 35,
  parameter int STEP_W     = 24,
  parameter int LEAK_SHIFT = 8
) (
  input  logic                                  clk_in,
  input  logic                                  rst_n_in,
  input  logic                                  sample_valid_in,
  input  logic signed [SAMPLE_W-1:0]            sample_in,
  output logic                                  sample_ready_out,
  input  logic                                  upd_valid_in,
  output logic                                  upd_ready_out,
  input  logic signed [SAMPLE_W-1:0]            error_in,
  input  logic [15:0]                           inv_norm_in,
  input  logic [4:0]                            mu_shift_in,
  input  logic                                  leak_en_in,
  input  logic                                  freeze_in,
  input  logic                                  clear_in,
  output logic [TAPS*COEFF_W-1:0]               coeffs_out,
  output logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] offset_out,
  output logic                                  busy_out,
  output logic                                  done_out,
  output logic                                  sat_out
);

  localparam int LOG_T  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PASSES = TAPS / LANES;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int PROD_W = 33;
  localparam int MAC_W  = STEP_W + SAMPLE_W;
  localparam int SUM_W  = ((ACC_W > MAC_W) ? ACC_W : MAC_W) + 1;

  localparam logic signed [PROD_W-1:0] STEP_MAX = {{(PROD_W-STEP_W+1){1'b0}}, {(STEP_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] STEP_MIN = {{(PROD_W-STEP_W+1){1'b1}}, {(STEP_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0]  ACC_MAX  = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0]  ACC_MIN  = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0]    acc     [TAPS];
  logic signed [SAMPLE_W-1:0] buf_mem [TAPS];

  logic [LOG_T-1:0]           wr_ptr_q;
  logic [LOG_T-1:0]           newest_q;
  logic [CNT_W-1:0]           upd_cnt_q;
  logic signed [STEP_W-1:0]   step_q;
  logic signed [SAMPLE_W-1:0] err_q;
  logic [15:0]                inv_q;
  logic [4:0]                 mu_q;
  logic                       leak_q;
  logic                       frz_q;
  logic                       sat_q;

  logic idle;
  logic sample_acc;
  logic upd_acc;
  logic last_pass;

  logic signed [PROD_W-1:0] err_ext;
  logic signed [PROD_W-1:0] inv_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic signed [STEP_W-1:0] step_d;
  logic                     step_ovf;

  logic [LOG_T-1:0]        tap_idx  [LANES];
  logic [LOG_T-1:0]        rd_idx   [LANES];
  logic signed [ACC_W-1:0] acc_base [LANES];
  logic signed [MAC_W-1:0] mac      [LANES];
  logic signed [SUM_W-1:0] sum      [LANES];
  logic signed [ACC_W-1:0] new_acc  [LANES];
  logic [LANES-1:0]        lane_sat;

  assign idle       = (state_q == S_IDLE);
  assign sample_acc = sample_valid_in && idle;
  assign upd_acc    = upd_valid_in && idle;
  assign last_pass  = (upd_cnt_q == CNT_W'(PASSES - 1));

  always_comb begin
    state_d          = state_q;
    sample_ready_out = 1'b0;
    upd_ready_out    = 1'b0;
    busy_out         = 1'b1;
    done_out         = 1'b0;
    case (state_q)
      S_IDLE: begin
        sample_ready_out = 1'b1;
        upd_ready_out    = 1'b1;
        busy_out         = 1'b0;
        if (upd_valid_in) state_d = S_STEP;
      end
      S_STEP:   state_d = S_UPDATE;
      S_UPDATE: if (last_pass) state_d = S_DONE;
      S_DONE: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Full-width signed product keeps the sign of the error through the shift.
  always_comb begin
    err_ext  = {{(PROD_W-SAMPLE_W){err_q[SAMPLE_W-1]}}, err_q};
    inv_ext  = {{(PROD_W-16){1'b0}}, inv_q};
    prod     = err_ext * inv_ext;
    shifted  = prod >>> mu_q;
    step_ovf = 1'b1;
    if (shifted > STEP_MAX)      step_d = STEP_MAX[STEP_W-1:0];
    else if (shifted < STEP_MIN) step_d = STEP_MIN[STEP_W-1:0];
    else begin
      step_d   = shifted[STEP_W-1:0];
      step_ovf = 1'b0;
    end
  end

  always_comb begin
    lane_sat = '0;
    for (int l = 0; l < LANES; l++) begin
      tap_idx[l]  = LOG_T'(int'(upd_cnt_q) * LANES + l);
      rd_idx[l]   = newest_q - tap_idx[l];
      acc_base[l] = leak_q ? (acc[tap_idx[l]] - (acc[tap_idx[l]] >>> LEAK_SHIFT))
                           : acc[tap_idx[l]];
      mac[l]      = step_q * buf_mem[rd_idx[l]];
      sum[l]      = {{(SUM_W-ACC_W){acc_base[l][ACC_W-1]}}, acc_base[l]}
                  + {{(SUM_W-MAC_W){mac[l][MAC_W-1]}}, mac[l]};
      if (sum[l] > ACC_MAX) begin
        new_acc[l]  = ACC_MAX[ACC_W-1:0];
        lane_sat[l] = 1'b1;
      end else if (sum[l] < ACC_MIN) begin
        new_acc[l]  = ACC_MIN[ACC_W-1:0];
        lane_sat[l] = 1'b1;
      end else begin
        new_acc[l]  = sum[l][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      upd_cnt_q <= '0;
      step_q    <= '0;
      err_q     <= '0;
      inv_q     <= '0;
      mu_q      <= '0;
      leak_q    <= 1'b0;
      frz_q     <= 1'b0;
      sat_q     <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        acc[k]     <= '0;
        buf_mem[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (sample_acc) begin
        buf_mem[wr_ptr_q] <= sample_in;
        wr_ptr_q          <= wr_ptr_q + LOG_T'(1);
      end
      // A same-cycle sample becomes the newest tap input of this update.
      if (upd_acc) begin
        err_q     <= error_in;
        inv_q     <= inv_norm_in;
        mu_q      <= mu_shift_in;
        leak_q    <= leak_en_in;
        frz_q     <= freeze_in;
        newest_q  <= sample_acc ? wr_ptr_q : (wr_ptr_q - LOG_T'(1));
        upd_cnt_q <= '0;
      end else if (clear_in && idle) begin
        sat_q <= 1'b0;
        for (int k = 0; k < TAPS; k++) acc[k] <= '0;
      end
      if (state_q == S_STEP) begin
        step_q <= step_d;
        if (step_ovf) sat_q <= 1'b1;
      end
      if (state_q == S_UPDATE) begin
        upd_cnt_q <= upd_cnt_q + CNT_W'(1);
        if (!frz_q) begin
          for (int l = 0; l < LANES; l++) acc[tap_idx[l]] <= new_acc[l];
          if (|lane_sat) sat_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    coeffs_out = '0;
    for (int k = 0; k < TAPS; k++)
      coeffs_out[k*COEFF_W +: COEFF_W] = acc[k][ACC_W-1 -: COEFF_W];
  end

  assign offset_out = wr_ptr_q;
  assign sat_out    = sat_q;

endmodule

// File: tb/tb_nlms_update_engine.sv
// tb/tb_nlms_update_engine.sv - Scoreboard bench for nlms_update_engine against an arithmetic model
module tb_nlms_update_engine;

  localparam int TAPS = 64, LANES = 4, SAMPLE_W = 16, COEFF_W = 10;
  localparam int ACC_W = 35, STEP_W = 24, LEAK_SHIFT = 8;
  localparam int LATENCY = TAPS / LANES + 2;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic sample_valid_in, upd_valid_in, leak_en_in, freeze_in, clear_in;
  logic signed [SAMPLE_W-1:0] sample_in, error_in;
  logic [15:0] inv_norm_in;
  logic [4:0]  mu_shift_in;
  logic sample_ready_out, upd_ready_out, busy_out, done_out, sat_out;
  logic [TAPS*COEFF_W-1:0] coeffs_out;
  logic [5:0] offset_out;

  nlms_update_engine #(
    .TAPS(TAPS), .LANES(LANES), .SAMPLE_W(SAMPLE_W), .COEFF_W(COEFF_W),
    .ACC_W(ACC_W), .STEP_W(STEP_W), .LEAK_SHIFT(LEAK_SHIFT)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .sample_valid_in(sample_valid_in), .sample_in(sample_in), .sample_ready_out(sample_ready_out),
    .upd_valid_in(upd_valid_in), .upd_ready_out(upd_ready_out),
    .error_in(error_in), .inv_norm_in(inv_norm_in), .mu_shift_in(mu_shift_in),
    .leak_en_in(leak_en_in), .freeze_in(freeze_in), .clear_in(clear_in),
    .coeffs_out(coeffs_out), .offset_out(offset_out),
    .busy_out(busy_out), .done_out(done_out), .sat_out(sat_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [TAPS*COEFF_W-1:0] coeffs;
    bit                      sat;
    int                      acc_cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  longint acc_m [TAPS];
  longint buf_m [TAPS];
  int     wr_m;
  bit     sat_m;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s got %0d exp %0d", name, got, exp);
  endtask

  task automatic chk_coeffs(input string name, input logic [TAPS*COEFF_W-1:0] e);
    int bad = -1;
    logic signed [COEFF_W-1:0] g, x;
    checks++;
    for (int k = 0; k < TAPS; k++)
      if (bad < 0 && coeffs_out[k*COEFF_W +: COEFF_W] !== e[k*COEFF_W +: COEFF_W]) bad = k;
    if (bad < 0) passed++;
    else begin
      g = coeffs_out[bad*COEFF_W +: COEFF_W];
      x = e[bad*COEFF_W +: COEFF_W];
      $display("FAIL %s tap %0d got %0d exp %0d", name, bad, g, x);
    end
  endtask

  function automatic longint satw(input longint x, input int w, output bit hit);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -mx - 1;
    hit = 1'b1;
    if (x > mx) return mx;
    if (x < mn) return mn;
    hit = 1'b0;
    return x;
  endfunction

  function automatic logic [TAPS*COEFF_W-1:0] exp_coeffs();
    logic [TAPS*COEFF_W-1:0] v = '0;
    longint q;
    for (int k = 0; k < TAPS; k++) begin
      q = acc_m[k] >>> (ACC_W - COEFF_W);
      v[k*COEFF_W +: COEFF_W] = q[COEFF_W-1:0];
    end
    return v;
  endfunction

  function automatic longint coeff(input int k);
    logic signed [COEFF_W-1:0] c = coeffs_out[k*COEFF_W +: COEFF_W];
    return longint'(c);
  endfunction

  // Whole update applied at once: step from the error, then every tap against x[newest-k].
  task automatic model_update(input logic signed [15:0] err, input logic [15:0] inv,
                              input int mu, input bit leak, input bit frz);
    longint step, a;
    int newest, idx;
    bit h;
    step = satw((longint'(err) * longint'(inv)) >>> mu, STEP_W, h);
    if (h) sat_m = 1'b1;
    newest = (wr_m + TAPS - 1) % TAPS;
    if (!frz)
      for (int k = 0; k < TAPS; k++) begin
        idx = (newest - k + TAPS) % TAPS;
        a = leak ? acc_m[k] - (acc_m[k] >>> LEAK_SHIFT) : acc_m[k];
        acc_m[k] = satw(a + step * buf_m[idx], ACC_W, h);
        if (h) sat_m = 1'b1;
      end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      acc_m[k] = 0;
      buf_m[k] = 0;
    end
    wr_m  = 0;
    sat_m = 1'b0;
    sbq.delete();
  endtask

  task automatic check_model(input string name);
    chk_coeffs(name, exp_coeffs());
    chk({name, "_sat"}, sat_out, sat_m);
    chk({name, "_offset"}, offset_out, wr_m);
  endtask

  task automatic put_sample(input logic signed [15:0] s);
    sample_valid_in = 1'b1;
    sample_in       = s;
    buf_m[wr_m] = longint'(s);
    wr_m = (wr_m + 1) % TAPS;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    for (int k = 0; k < TAPS; k++) acc_m[k] = 0;
    sat_m = 1'b0;
    @(negedge clk_in);
    clear_in = 1'b0;
  endtask

  task automatic issue_update(input logic signed [15:0] err, input logic [15:0] inv,
                              input logic [4:0] mu, input bit leak, input bit frz,
                              input bit ws, input logic signed [15:0] s, input bit clr);
    exp_t e;
    upd_valid_in = 1'b1;
    error_in     = err;
    inv_norm_in  = inv;
    mu_shift_in  = mu;
    leak_en_in   = leak;
    freeze_in    = frz;
    clear_in     = clr;
    if (ws) begin
      sample_valid_in = 1'b1;
      sample_in       = s;
      buf_m[wr_m] = longint'(s);
      wr_m = (wr_m + 1) % TAPS;
    end
    model_update(err, inv, int'(mu), leak, frz);
    e.coeffs  = exp_coeffs();
    e.sat     = sat_m;
    e.acc_cyc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk_in);
    upd_valid_in    = 1'b0;
    sample_valid_in = 1'b0;
    clear_in        = 1'b0;
  endtask

  // While busy, optionally offer a sample, update and clear that must all be ignored.
  task automatic wait_done(input bit poke);
    int n = 0;
    while (!done_out && n < 3 * LATENCY) begin
      if (poke && n == 3) begin
        chk("ready_while_busy", sample_ready_out, 0);
        chk("busy_while_busy", busy_out, 1);
        sample_valid_in = 1'b1;
        sample_in       = 16'($urandom);
        upd_valid_in    = 1'b1;
        clear_in        = 1'b1;
      end else begin
        sample_valid_in = 1'b0;
        upd_valid_in    = 1'b0;
        clear_in        = 1'b0;
      end
      @(negedge clk_in);
      n++;
    end
    sample_valid_in = 1'b0;
    upd_valid_in    = 1'b0;
    clear_in        = 1'b0;
    if (!done_out) chk("done_timeout", 0, 1);
    @(negedge clk_in);
  endtask

  task automatic update(input logic signed [15:0] err, input logic [15:0] inv,
                        input logic [4:0] mu, input bit leak, input bit frz);
    issue_update(err, inv, mu, leak, frz, 1'b0, 16'sd0, 1'b0);
    wait_done(1'b0);
  endtask

  always @(negedge clk_in) begin
    if (rst_n_in && done_out) begin
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        chk_coeffs("sb_coeffs", mon_e.coeffs);
        chk("sb_sat", sat_out, mon_e.sat);
        chk("sb_latency", cyc - mon_e.acc_cyc + 1, LATENCY);
      end
    end
  end

  initial begin
    int done_cnt;
    logic signed [15:0] r;
    rst_n_in = 1'b0;
    sample_valid_in = 1'b0; upd_valid_in = 1'b0; leak_en_in = 1'b0;
    freeze_in = 1'b0; clear_in = 1'b0; sample_in = '0; error_in = '0;
    inv_norm_in = '0; mu_shift_in = '0;
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check_model("reset");
    chk("reset_busy", busy_out, 0);
    chk("reset_done", done_out, 0);
    chk("reset_ready", upd_ready_out, 1);

    put_sample(16'sd320);
    update(16'sd256, 16'd4096, 5'd0, 1'b0, 1'b0);
    chk("basic_c0", coeff(0), 10);
    chk("basic_c1", coeff(1), 0);
    update(-16'sd256, 16'd4096, 5'd0, 1'b0, 1'b0);
    chk("neg_c0_zero", coeff(0), 0);
    update(-16'sd256, 16'd4096, 5'd0, 1'b0, 1'b0);
    chk("neg_c0", coeff(0), -10);
    update(16'sd12345, 16'd5000, 5'd2, 1'b0, 1'b1);
    chk("freeze_c0", coeff(0), -10);

    rst_n_in = 1'b0;
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < TAPS; i++) put_sample(16'sd32767);
    update(16'sd32767, 16'd65535, 5'd0, 1'b0, 1'b0);
    update(16'sd32767, 16'd65535, 5'd0, 1'b0, 1'b0);
    chk("sat_c0", coeff(0), 511);
    chk("sat_c63", coeff(TAPS - 1), 511);
    chk("sat_flag", sat_out, 1);
    do_clear();
    check_model("clear");
    chk("clear_sat", sat_out, 0);

    for (int i = 0; i < TAPS + 1; i++) put_sample(16'($urandom));
    chk("wrap_offset", offset_out, 1);
    issue_update(16'sd1000, 16'd30000, 5'd4, 1'b0, 1'b0, 1'b1, 16'sd20000, 1'b0);
    wait_done(1'b1);
    check_model("same_cycle");
    issue_update(16'sd700, 16'd9000, 5'd6, 1'b1, 1'b0, 1'b0, 16'sd0, 1'b1);
    wait_done(1'b0);
    check_model("upd_over_clear");

    for (int it = 0; it < 40; it++) begin
      int ns = $urandom_range(0, 3);
      for (int j = 0; j < ns; j++) put_sample(16'($urandom));
      if ($urandom_range(0, 9) == 0) do_clear();
      r = 16'($urandom);
      issue_update(16'($urandom), 16'($urandom), 5'($urandom_range(6, 24)),
                   1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom), r,
                   ($urandom_range(0, 4) == 0));
      wait_done(it % 3 == 0);
      check_model("rand");
    end

    issue_update(16'sd3000, 16'd20000, 5'd3, 1'b0, 1'b0, 1'b0, 16'sd0, 1'b0);
    repeat (6) @(negedge clk_in);
    rst_n_in = 1'b0;
    model_reset();
    #1;
    chk_coeffs("midreset_coeffs", exp_coeffs());
    chk("midreset_sat", sat_out, 0);
    chk("midreset_busy", busy_out, 0);
    chk("midreset_done", done_out, 0);
    chk("midreset_offset", offset_out, 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 3 * LATENCY; i++) begin
      @(negedge clk_in);
      if (done_out) done_cnt++;
    end
    chk("midreset_no_done", done_cnt, 0);
    chk("final_queue_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/nlms_update_engine.md
NLMS_UPDATE_ENGINE -- requirements
Module: nlms_update_engine

Interface
REQ-001 SHALL have parameter TAPS, default 64, meaning filter length (power of 2, >= LANES).
REQ-002 SHALL have parameter LANES, default 4, meaning taps updated per cycle (power of 2, divides TAPS).
REQ-003 SHALL have parameter SAMPLE_W, default 16, meaning signed sample and error width.
REQ-004 SHALL have parameter COEFF_W, default 10, meaning signed output coefficient width.
REQ-005 SHALL have parameter ACC_W, default 35, meaning signed coefficient accumulator width.
REQ-006 SHALL have parameter STEP_W, default 24, meaning signed step width.
REQ-007 SHALL have parameter LEAK_SHIFT, default 8, meaning leakage divisor as a power of 2.
REQ-008 SHALL have port clk_in, input, 1 bit, meaning the single clock.
REQ-009 SHALL have port rst_n_in, input, 1 bit, meaning asynchronous active-low reset.
REQ-010 SHALL have port sample_valid_in, input, 1 bit, meaning a new sample is offered.
REQ-011 SHALL have port sample_in, input, SAMPLE_W bits, meaning signed reference sample.
REQ-012 SHALL have port sample_ready_out, output, 1 bit, meaning a sample can be accepted.
REQ-013 SHALL have port upd_valid_in, input, 1 bit, meaning an update is requested.
REQ-014 SHALL have port upd_ready_out, output, 1 bit, meaning an update can be accepted.
REQ-015 SHALL have port error_in, input, SAMPLE_W bits, meaning signed error.
REQ-016 SHALL have port inv_norm_in, input, 16 bits, meaning unsigned reciprocal input power.
REQ-017 SHALL have port mu_shift_in, input, 5 bits, meaning step-size right shift.
REQ-018 SHALL have port leak_en_in, input, 1 bit, meaning apply leakage on this update.
REQ-019 SHALL have port freeze_in, input, 1 bit, meaning run the update without changing coefficients.
REQ-020 SHALL have port clear_in, input, 1 bit, meaning synchronous coefficient clear.
REQ-021 SHALL have port coeffs_out, output, TAPS x COEFF_W bits, meaning acc[k][ACC_W-1 -: COEFF_W] for each tap k.
REQ-022 SHALL have port offset_out, output, log2(TAPS) bits, meaning the next sample write index.
REQ-023 SHALL have port busy_out, output, 1 bit, meaning the FSM is not in IDLE.
REQ-024 SHALL have port done_out, output, 1 bit, meaning a one-cycle pulse when an update completes.
REQ-025 SHALL have port sat_out, output, 1 bit, meaning a sticky saturation flag.

Function
REQ-026 SHALL implement FSM IDLE -> STEP -> UPDATE -> DONE -> IDLE.
REQ-027 SHALL drive sample_ready_out = upd_ready_out = (state==IDLE).
REQ-028 SHALL, on an accepted sample, write sample_in to buf[wr_ptr] and set wr_ptr <= wr_ptr+1 mod TAPS, wrapping TAPS-1 -> 0.
REQ-029 SHALL, on an accepted update, latch error_in, inv_norm_in, mu_shift_in, leak_en_in and freeze_in, latch newest = index of the most recently written sample, and go to STEP.
REQ-030 SHALL, when a sample and an update are accepted in the same cycle, write the sample first so that newest is that sample's index.
REQ-031 SHALL compute in STEP the registered value step = sat_STEP_W((error * inv_norm) >>> mu_shift), using an arithmetic shift on the full 33-bit signed product.
REQ-032 SHALL, in UPDATE cycle c (0..TAPS/LANES-1), process lanes l = 0..LANES-1 on tap k = c*LANES+l.
REQ-033 SHALL compute for each such tap acc[k] <= sat_ACC_W(a + step*buf[(newest-k) mod TAPS]), where a = acc[k] - (acc[k] >>> LEAK_SHIFT) if leak is enabled, else acc[k].
REQ-034 SHALL spend exactly TAPS/LANES cycles in UPDATE, then spend 1 cycle in DONE with done_out=1; done occurs TAPS/LANES+2 cycles after accept (18 cycles at default parameters).
REQ-035 SHALL, when freeze is latched, run the full FSM timing including done_out but leave acc unchanged.
REQ-036 SHALL set sat_out on any step or accumulator saturation; only reset or clear_in clears it.
REQ-037 SHALL, on clear_in in IDLE, zero all acc and sat_out; SHALL ignore clear_in outside IDLE; SHALL not clear buf.
REQ-038 SHALL give an accepted update priority over clear_in in the same cycle.
REQ-039 SHALL not accept or drop-write samples while busy.

Reset
REQ-040 SHALL, while rst_n_in=0, immediately force state=IDLE, every acc=0, every buf entry=0, wr_ptr=0, done_out=0, sat_out=0 and step=0, so that coeffs_out=0 and busy_out=0.
REQ-041 SHALL abandon any update in progress on reset assertion mid-operation, with no done_out pulse.

Verification
REQ-042 Write sample 320 at index 0 (all others 0), then update with error=256, inv_norm=4096, mu=0 -> done after 18 cycles, coeffs_out[0]=10, all others 0, sat_out=0.
REQ-043 Repeat REQ-042 with error=-256 -> coeffs_out[0] returns to 0; issue one more -256 update -> coeffs_out[0]=-10.
REQ-044 Set error=32767, inv_norm=65535, samples of 32767, repeated updates -> step saturates to 8388607, coeffs_out reaches 511 and holds, sat_out=1; clear_in -> all coeffs 0 and sat_out=0.
REQ-045 Write 65 samples -> offset_out=1 and the 65th sample sits in buf[0]; sample and update in the same cycle -> coefficient k uses the just-written sample at k=0.
REQ-046 Assert freeze_in with any update -> coeffs unchanged and done_out still pulses at cycle 18; assert rst_n_in low at UPDATE cycle 5 -> all outputs 0 at once and no done_out pulse.
